dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
Byte-addressed, little-endian data memory for the riscv64i load/store path. It supersedes the doubleword-indexed RAM: sub-word accesses are placed by address offset and byte strobes, misalignment and illegal widths raise a fault, and read latency is configurable. Requests and responses use a valid/ready handshake with one transaction outstanding. It sits between the MEM stage and the backing storage array.

Parameters:
DATA_WIDTH, 64, word width in bits; legal values are 32 or 64.
ADDR_WIDTH, 16, byte-address width; depth is 2**ADDR_WIDTH / (DATA_WIDTH/8) words.
READ_LATENCY, 1, cycles from read accept to resp_valid; legal range 1..4.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_we  in  1  1 = store, 0 = load
req_wid  in  3  width code: B=000 H=001 W=010 D=011 BU=100 HU=101 WU=110; 111 is illegal
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, LSB-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_rdata  out  DATA_WIDTH  load result, sign- or zero-extended; 0 for stores and faults
resp_fault  out  1  misaligned access or illegal width

Behaviour:
- Address split: offset = req_addr[log2(DATA_WIDTH/8)-1:0]; word index = the remaining upper bits.
- Accept condition: req_valid && req_ready at a rising edge. req_ready = (state==IDLE).
- FSM states:
  - IDLE -> READ on an accepted legal load.
  - IDLE -> RESP on an accepted store or any fault.
  - READ counts READ_LATENCY-1 further cycles, then -> RESP. With READ_LATENCY=1, READ lasts 0 cycles and goes directly to RESP.
  - RESP holds resp_valid=1 and stable outputs until resp_ready=1, then -> IDLE on that edge.
- Latency:
  - Store or fault: resp_valid is high the cycle after accept.
  - Load: resp_valid is high READ_LATENCY cycles after accept.
- Alignment rules:
  - H/HU require addr[0]=0.
  - W/WU require addr[1:0]=0.
  - D requires addr[2:0]=0.
  - Violation -> fault.
- Width legality: when DATA_WIDTH=32, D and WU are illegal and fault. Code 111 faults for a store or a load.
- Fault response: resp_fault=1, resp_rdata=0, memory unchanged.
- Store commit: at the accept edge, using per-byte enables.
  - Strobe = (1<<size)-1 shifted left by offset.
  - Data = req_wdata shifted left by 8*offset.
  - BU/HU/WU codes on a store are treated as B/H/W.
- Load path:
  - The array word is captured at the accept edge and held through READ.
  - Lanes are extracted at offset and extended per width: B/H/W sign-extend; BU/HU/WU zero-extend; D is unmodified.
- Store followed by load to the same address returns the new data, since the store commits before the load can be accepted.
- resp_rdata and resp_fault are registered and stable while resp_valid=1. Their values are don't-care-free: they are 0 when resp_valid=0.
- Reset:
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, latency counter=0.
  - Any pending or unconsumed response is dropped.
  - A store accepted in the same cycle rst is high does not commit.
  - Array contents are not reset.
- req_ready=0 while rst=1.

Decomposition:
- Package dmem_pkg holds:
  - the mem_wid_e enum (seven codes above plus MEM_ILL=3'b111);
  - function wid_size_log2(mem_wid_e) returning 0..3;
  - function wid_is_signed;
  - function is_misaligned(wid, offset).
- Sub-module dmem_lane_align is combinational: word + offset + wid -> extended result, plus byte strobe and shifted store data. It is instantiated once in dmem_ctrl.
- The byte array and FSM live in dmem_ctrl.

Test Plan:
1. Store D 0x1122334455667788 @0x0010, then load BU @0x0013 -> resp_rdata 0x0000000000000055, fault 0. Then load H @0x0016 -> 0x0000000000001122.
2. Store B 0xF0 @0x0021, then load B @0x0021 -> 0xFFFFFFFFFFFFFFF0. Load D @0x0020 -> only byte1 = 0xF0, other bytes keep their prior values.
3. Load W @0x0006 -> resp_fault 1, rdata 0. Store D @0x0004 -> fault 1, and a subsequent load D @0x0000 shows the array unchanged. Any request with wid=111 -> fault 1.
4. READ_LATENCY=3: load accepted at cycle t -> resp_valid rises at t+3. Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and fault stay stable and req_ready stays 0. resp_ready=1 -> next cycle req_ready=1.
5. Assert rst while in READ and again while in RESP -> next cycle resp_valid=0, req_ready=1. A store held with req_valid during rst does not modify the array.
6. DATA_WIDTH=32: store W 0xDEADBEEF @0x8, load HU @0xA -> 0x0000DEAD. Load D @0x8 -> fault 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared width codes and helpers for the byte-addressed data memory.
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B   = 3'b000,
        MEM_H   = 3'b001,
        MEM_W   = 3'b010,
        MEM_D   = 3'b011,
        MEM_BU  = 3'b100,
        MEM_HU  = 3'b101,
        MEM_WU  = 3'b110,
        MEM_ILL = 3'b111
    } mem_wid_e;

    function automatic logic [1:0] wid_size_log2(input mem_wid_e wid);
        case (wid)
            MEM_H, MEM_HU: return 2'd1;
            MEM_W, MEM_WU: return 2'd2;
            MEM_D:         return 2'd3;
            default:       return 2'd0;
        endcase
    endfunction

    function automatic logic wid_is_signed(input mem_wid_e wid);
        return (wid == MEM_B) || (wid == MEM_H) || (wid == MEM_W);
    endfunction

    function automatic logic is_misaligned(input mem_wid_e wid, input logic [2:0] offset);
        case (wid_size_log2(wid))
            2'd1:    return offset[0];
            2'd2:    return offset[1:0] != 2'd0;
            2'd3:    return offset != 3'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extraction/extension, store strobe and data placement.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]             word,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset,
    input  mem_wid_e                          wid,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic [DATA_WIDTH/8-1:0]           strobe,
    output logic [DATA_WIDTH-1:0]             wdata_sh
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic                  msb;
    logic [7:0]            strb;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        mask    = '1;
        msb     = shifted[DATA_WIDTH-1];
        strb    = 8'hFF;
        case (wid_size_log2(wid))
            2'd0: begin
                mask = DATA_WIDTH'(64'hFF);
                msb  = shifted[7];
                strb = 8'h01;
            end
            2'd1: begin
                mask = DATA_WIDTH'(64'hFFFF);
                msb  = shifted[15];
                strb = 8'h03;
            end
            2'd2: begin
                mask = DATA_WIDTH'(64'hFFFF_FFFF);
                msb  = shifted[31];
                strb = 8'h0F;
            end
            default: ;
        endcase
        rdata = shifted & mask;
        if (wid_is_signed(wid) && msb) begin
            rdata = rdata | ~mask;
        end
        strobe   = NB'(strb) << offset;
        wdata_sh = wdata << {offset, 3'b000};
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with valid/ready handshake and configurable latency.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_wid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = ADDR_WIDTH - OFF_W;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state_q;
    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fault_q;

    mem_wid_e              wid;
    logic [OFF_W-1:0]      offset;
    logic [IDX_W-1:0]      word_idx;
    logic                  illegal;
    logic                  fault;
    logic                  accept;
    logic                  store_commit;
    logic [DATA_WIDTH-1:0] load_data;
    logic [NB-1:0]         strobe;
    logic [DATA_WIDTH-1:0] wdata_sh;

    assign wid      = mem_wid_e'(req_wid);
    assign offset   = req_addr[OFF_W-1:0];
    assign word_idx = req_addr[ADDR_WIDTH-1:OFF_W];
    assign illegal  = (wid == MEM_ILL) ||
                      ((DATA_WIDTH == 32) && ((wid == MEM_D) || (wid == MEM_WU)));
    assign fault    = illegal || is_misaligned(wid, 3'(offset));

    assign req_ready    = (state_q == StIdle) && !rst;
    assign accept       = req_valid && req_ready;
    assign store_commit = accept && req_we && !fault;

    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    dmem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .word    (mem[word_idx]),
        .offset  (offset),
        .wid     (wid),
        .wdata   (req_wdata),
        .rdata   (load_data),
        .strobe  (strobe),
        .wdata_sh(wdata_sh)
    );

    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (strobe[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // The extended load result is held in hold_q so resp_rdata stays 0 until the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            hold_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (fault) begin
                            state_q <= StResp;
                            rdata_q <= '0;
                            fault_q <= 1'b1;
                        end else if (req_we) begin
                            state_q <= StResp;
                            rdata_q <= '0;
                            fault_q <= 1'b0;
                        end else if (READ_LATENCY <= 1) begin
                            state_q <= StResp;
                            rdata_q <= load_data;
                            fault_q <= 1'b0;
                        end else begin
                            state_q <= StRead;
                            hold_q  <= load_data;
                            cnt_q   <= 2'(READ_LATENCY - 1);
                        end
                    end
                end
                StRead: begin
                    if (cnt_q <= 2'd1) begin
                        state_q <= StResp;
                        cnt_q   <= 2'd0;
                        rdata_q <= hold_q;
                        fault_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                        rdata_q <= '0;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
